// File: rtl/com_mem_mailbox_reader.sv
// Polls a mailbox descriptor in shared memory, streams its payload words out,
// then clears the descriptor's valid flag byte to hand the mailbox back.
module com_mem_mailbox_reader #(
  parameter int unsigned DESC_ADDR = 0,
  parameter int unsigned POLL_GAP  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic [9:0]  address,
  output logic        chipselect,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata,
  output logic [31:0] st_data,
  output logic        st_valid,
  output logic        st_sop,
  output logic        st_eop,
  input  logic        st_ready,
  output logic        busy,
  output logic [15:0] frames_done
);

  localparam logic [9:0]  DescAddr = 10'(DESC_ADDR);
  localparam logic [15:0] GapLast  = 16'(POLL_GAP - 1);

  typedef enum logic [2:0] {
    StIdle, StPoll, StCheck, StRead, StFetch, StSend, StClear, StGap
  } state_e;

  state_e      state_q, state_d;
  logic [9:0]  idx_q, idx_d;
  logic [9:0]  len_q, len_d;
  logic [15:0] gap_q, gap_d;
  logic [15:0] frames_q, frames_d;
  logic [31:0] data_q, data_d;
  logic        sop_q, sop_d;
  logic        eop_q, eop_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      len_q    <= '0;
      gap_q    <= '0;
      frames_q <= '0;
      data_q   <= '0;
      sop_q    <= 1'b0;
      eop_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      len_q    <= len_d;
      gap_q    <= gap_d;
      frames_q <= frames_d;
      data_q   <= data_d;
      sop_q    <= sop_d;
      eop_q    <= eop_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    len_d      = len_q;
    gap_d      = gap_q;
    frames_d   = frames_q;
    data_d     = data_q;
    sop_d      = sop_q;
    eop_d      = eop_q;
    address    = '0;
    chipselect = 1'b0;
    write      = 1'b0;
    writedata  = '0;
    byteenable = '0;
    st_valid   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (enable) state_d = StPoll;
      end
      StPoll: begin
        chipselect = 1'b1;
        address    = DescAddr;
        state_d    = StCheck;
      end
      StCheck: begin
        len_d = readdata[9:0];
        if (!readdata[31]) begin
          state_d = StGap;
        end else if (readdata[9:0] == 10'd0) begin
          state_d = StClear;
        end else begin
          idx_d   = 10'd1;
          state_d = StRead;
        end
      end
      StRead: begin
        chipselect = 1'b1;
        address    = DescAddr + idx_q;  // wraps modulo 1024
        state_d    = StFetch;
      end
      StFetch: begin
        data_d  = readdata;
        sop_d   = (idx_q == 10'd1);
        eop_d   = (idx_q == len_q);
        state_d = StSend;
      end
      StSend: begin
        st_valid = 1'b1;
        if (st_ready) begin
          if (idx_q == len_q) begin
            state_d = StClear;
          end else begin
            idx_d   = idx_q + 10'd1;
            state_d = StRead;
          end
        end
      end
      StClear: begin
        // Zero only the top byte so LEN survives for anyone inspecting memory.
        chipselect = 1'b1;
        write      = 1'b1;
        address    = DescAddr;
        byteenable = 4'b1000;
        frames_d   = frames_q + 16'd1;
        state_d    = StGap;
      end
      StGap: begin
        if (gap_q == GapLast) begin
          gap_d   = '0;
          state_d = StIdle;
        end else begin
          gap_d = gap_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign st_data     = data_q;
  assign st_sop      = sop_q;
  assign st_eop      = eop_q;
  assign busy        = (state_q != StIdle) && (state_q != StGap);
  assign frames_done = frames_q;

endmodule

// File: tb/tb_com_mem_mailbox_reader.sv
// Bench for com_mem_mailbox_reader: memory model, stream scoreboard and a
// table of descriptors, plus hand-written stall and mid-frame reset sequences.
module tb_com_mem_mailbox_reader;

  localparam int unsigned DESC = 1022;
  localparam int unsigned GAP  = 4;

  logic        clk = 1'b0;
  logic        reset, enable, chipselect, write, st_valid, st_sop, st_eop, st_ready, busy;
  logic [9:0]  address;
  logic [31:0] writedata, readdata, st_data;
  logic [3:0]  byteenable;
  logic [15:0] frames_done;

  always #5 clk = ~clk;

  com_mem_mailbox_reader #(.DESC_ADDR(DESC), .POLL_GAP(GAP)) dut (
    .clk(clk), .reset(reset), .enable(enable), .address(address), .chipselect(chipselect),
    .write(write), .writedata(writedata), .byteenable(byteenable), .readdata(readdata),
    .st_data(st_data), .st_valid(st_valid), .st_sop(st_sop), .st_eop(st_eop),
    .st_ready(st_ready), .busy(busy), .frames_done(frames_done)
  );

  typedef struct {
    logic [31:0] desc;
    bit          rand_ready;
    int          n_words;
    int          n_frames;
    logic [31:0] mem_after;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        sop;
    logic        eop;
  } word_t;

  word_t       exp_q[$];
  logic [31:0] mem [1024];
  logic        ld_en;
  logic [9:0]  ld_addr;
  logic [31:0] ld_data;

  int checks = 0, errors = 0, cyc = 0;
  int wr_cnt = 0, word_cnt = 0, poll_cnt = 0, last_poll = -1, last_hs = 0, wr_gap = 0;
  bit track_poll = 0, fast = 0, rand_mode = 0;
  logic        prev_stall = 1'b0;
  logic [33:0] prev_word = '0;
  logic [15:0] fd_exp = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_mode) st_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic mem_load(input logic [9:0] a, input logic [31:0] d);
    ld_addr = a;
    ld_data = d;
    ld_en   = 1'b1;
    step();
    ld_en   = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_bus"}, 64'({address, chipselect, write, byteenable, writedata}), 64'(0));
    check({tag, "_stream"}, 64'({st_data, st_valid, st_sop, st_eop, busy, frames_done}), 64'(0));
  endtask

  task automatic wait_frames(input logic [15:0] target, input int budget);
    int n = 0;
    while (!(frames_done == target && !busy) && n < budget) begin
      step();
      n++;
    end
    check("frames_done", 64'(frames_done), 64'(target));
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!st_valid && n < budget) begin
      step();
      n++;
    end
    check("st_valid_seen", 64'(st_valid), 64'(1));
  endtask

  task automatic go_idle();
    int n = 0;
    enable    = 1'b0;
    rand_mode = 0;
    st_ready  = 1'b1;
    while (busy && n < 200) begin
      step();
      n++;
    end
    check("idle_reached", 64'(busy), 64'(0));
    repeat (GAP + 3) step();
  endtask

  // Memory model: registered read data, byte-lane writes, bench-side loads.
  initial forever begin
    @(posedge clk);
    if (chipselect && !write) readdata <= mem[address];
    if (chipselect && write)
      for (int b = 0; b < 4; b++)
        if (byteenable[b]) mem[address][8*b +: 8] <= writedata[8*b +: 8];
    if (ld_en) mem[ld_addr] <= ld_data;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Bus and stream monitor with scoreboard pop.
  initial forever begin
    @(negedge clk);
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (chipselect && !write && address == 10'(DESC)) begin
        poll_cnt++;
        if (track_poll && last_poll >= 0)
          check("poll_interval", 64'(cyc - last_poll), 64'(GAP + 3));
        last_poll = cyc;
      end
      if (chipselect && write) begin
        wr_cnt++;
        wr_gap = cyc - last_poll;
        check("clear_write", 64'({address, byteenable, writedata}),
              64'({10'(DESC), 4'b1000, 32'h0}));
      end
      if (prev_stall)
        check("hold_stable", 64'({st_valid, st_data, st_sop, st_eop}), 64'({1'b1, prev_word}));
      if (st_valid && st_ready) begin
        word_cnt++;
        check("stream_word_expected", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) begin
          word_t e;
          e = exp_q.pop_front();
          check("stream_word", 64'({st_data, st_sop, st_eop}), 64'({e.data, e.sop, e.eop}));
          if (fast && !st_sop) check("word_spacing", 64'(cyc - last_hs), 64'(3));
        end
        last_hs = cyc;
      end
      prev_stall = st_valid && !st_ready;
      prev_word  = {st_data, st_sop, st_eop};
    end
  end

  initial begin
    vec_t vecs[6];
    int   w0, wr0, p0;
    vecs[0] = '{32'h8000_0003, 1'b0, 3, 1, 32'h0000_0003};
    vecs[1] = '{32'h8000_0000, 1'b0, 0, 1, 32'h0000_0000};
    vecs[2] = '{32'hFFFF_0002, 1'b0, 2, 1, 32'h00FF_0002};
    vecs[3] = '{32'h0000_0005, 1'b0, 0, 0, 32'h0000_0005};
    vecs[4] = '{32'h8000_0004, 1'b1, 4, 1, 32'h0000_0004};
    vecs[5] = '{32'h8123_4401, 1'b0, 1, 1, 32'h0023_4401};

    reset = 1'b1; enable = 1'b0; st_ready = 1'b1;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    step();
    reset = 1'b0;
    step();
    check_zero("after_release");

    // Empty mailbox: periodic polls only.
    mem_load(10'(DESC), 32'h0);
    w0 = word_cnt; wr0 = wr_cnt; p0 = poll_cnt;
    last_poll  = -1;
    track_poll = 1;
    enable     = 1'b1;
    repeat (60) step();
    enable     = 1'b0;
    track_poll = 0;
    check("poll_count_min", 64'(poll_cnt - p0 >= 8), 64'(1));
    check("idle_no_write", 64'(wr_cnt - wr0), 64'(0));
    check("idle_no_stream", 64'(word_cnt - w0), 64'(0));
    go_idle();

    for (int i = 0; i < 6; i++) begin
      int len;
      len = int'(vecs[i].desc[9:0]);
      mem_load(10'(DESC), vecs[i].desc);
      for (int k = 1; k <= len; k++)
        mem_load(10'(DESC + k), 32'hC0DE_0000 | 32'(i << 8) | 32'(k));
      for (int k = 1; k <= vecs[i].n_words; k++)
        exp_q.push_back('{32'hC0DE_0000 | 32'(i << 8) | 32'(k), k == 1, k == vecs[i].n_words});
      fd_exp    = fd_exp + 16'(vecs[i].n_frames);
      w0        = word_cnt;
      wr0       = wr_cnt;
      fast      = !vecs[i].rand_ready;
      rand_mode = vecs[i].rand_ready;
      enable    = 1'b1;
      repeat (20) step();
      wait_frames(fd_exp, 400);
      go_idle();
      check("desc_after", 64'(mem[10'(DESC)]), 64'(vecs[i].mem_after));
      check("word_count", 64'(word_cnt - w0), 64'(vecs[i].n_words));
      check("queue_drained", 64'(exp_q.size()), 64'(0));
      check("write_count", 64'(wr_cnt - wr0), 64'(vecs[i].n_frames));
      if (vecs[i].n_words == 0 && vecs[i].n_frames == 1)
        check("len0_clear_after_check", 64'(wr_gap), 64'(2));
    end

    // Single word held by a stalled sink for 10 cycles.
    mem_load(10'(DESC), 32'h8000_0001);
    mem_load(10'(DESC + 1), 32'h5A5A_1234);
    exp_q.push_back('{32'h5A5A_1234, 1'b1, 1'b1});
    fast = 0; st_ready = 1'b0; wr0 = wr_cnt; enable = 1'b1;
    wait_valid(50);
    repeat (10) begin
      check("stall_hold", 64'({st_valid, st_data, st_sop, st_eop}), 64'({1'b1, 32'h5A5A_1234, 2'b11}));
      check("stall_no_clear", 64'(wr_cnt - wr0), 64'(0));
      step();
    end
    st_ready = 1'b1;
    fd_exp   = fd_exp + 16'd1;
    wait_frames(fd_exp, 50);
    go_idle();
    check("stall_clear_count", 64'(wr_cnt - wr0), 64'(1));
    check("stall_desc_after", 64'(mem[10'(DESC)]), 64'(32'h0000_0001));

    // Reset while word 2 sits in SEND; the frame must replay from word 1.
    mem_load(10'(DESC), 32'h8000_0003);
    for (int k = 1; k <= 3; k++) mem_load(10'(DESC + k), 32'hBEEF_0000 | 32'(k));
    for (int k = 1; k <= 3; k++) exp_q.push_back('{32'hBEEF_0000 | 32'(k), k == 1, k == 3});
    fast = 0; st_ready = 1'b0; wr0 = wr_cnt; enable = 1'b1;
    wait_valid(50);
    st_ready = 1'b1;
    step();
    st_ready = 1'b0;
    wait_valid(50);
    check("word2_in_send", 64'({st_valid, st_sop, st_data}), 64'({2'b10, 32'hBEEF_0002}));
    reset = 1'b1;
    #1;
    check_zero("reset_mid_frame");
    exp_q.delete();
    fd_exp = '0;
    step();
    check("reset_desc_kept", 64'(mem[10'(DESC)]), 64'(32'h8000_0003));
    check("reset_no_clear", 64'(wr_cnt - wr0), 64'(0));
    reset    = 1'b0;
    st_ready = 1'b1;
    fast     = 1;
    w0       = word_cnt;
    for (int k = 1; k <= 3; k++) exp_q.push_back('{32'hBEEF_0000 | 32'(k), k == 1, k == 3});
    fd_exp = 16'd1;
    wait_frames(fd_exp, 100);
    go_idle();
    check("replay_words", 64'(word_cnt - w0), 64'(3));
    check("replay_desc_after", 64'(mem[10'(DESC)]), 64'(32'h0000_0003));
    check("replay_clear_count", 64'(wr_cnt - wr0), 64'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/com_mem_mailbox_reader.md
COM_MEM_MAILBOX_READER -- requirements
Module: com_mem_mailbox_reader

Interface
REQ-001 Parameter: DESC_ADDR, 0, word address of the mailbox descriptor in the shared memory.
REQ-002 Parameter: POLL_GAP, 16, idle cycles between descriptor polls (range 1..65535).
REQ-003 Port: clk  input  1  sole clock; all logic rising-edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: enable  input  1  permits starting a new descriptor poll.
REQ-006 Port: address  output  10  memory word address.
REQ-007 Port: chipselect  output  1  memory access strobe.
REQ-008 Port: write  output  1  write qualifier, valid with chipselect.
REQ-009 Port: writedata  output  32  write data.
REQ-010 Port: byteenable  output  4  write byte lanes.
REQ-011 Port: readdata  input  32  memory read data, valid exactly 1 cycle after a read strobe; no waitrequest.
REQ-012 Port: st_data  output  32  stream payload word.
REQ-013 Port: st_valid / st_sop / st_eop  output  1 each  stream valid, first word, last word.
REQ-014 Port: st_ready  input  1  stream sink ready.
REQ-015 Port: busy  output  1  high in any state other than IDLE and GAP.
REQ-016 Port: frames_done  output  16  count of completed descriptors, wraps at 65535->0.

Function
REQ-017 Descriptor word: bit31 = valid flag, bits[9:0] = LEN (payload words, 0..1023); all other bits are ignored.
REQ-018 Payload word k (1..LEN) is located at (DESC_ADDR + k) mod 1024.
REQ-019 States: IDLE, POLL, CHECK, READ, FETCH, SEND, CLEAR, GAP.
REQ-020 IDLE: when enable=1, transition to POLL; otherwise remain in IDLE; no bus activity.
REQ-021 POLL (1 cycle): chipselect=1, write=0, address=DESC_ADDR; then CHECK.
REQ-022 CHECK (1 cycle): latch readdata; valid=0 -> GAP; valid=1, LEN=0 -> CLEAR; otherwise idx=1 -> READ.
REQ-023 READ (1 cycle): chipselect=1, write=0, address=DESC_ADDR+idx; then FETCH.
REQ-024 FETCH (1 cycle): load st_data from readdata; st_sop=(idx==1); st_eop=(idx==LEN); then SEND.
REQ-025 SEND: st_valid=1, with st_data/st_sop/st_eop held stable until st_ready=1.
REQ-026 SEND on st_ready=1: idx==LEN -> CLEAR; otherwise idx+1 -> READ; st_valid drops the following cycle.
REQ-027 CLEAR (1 cycle): chipselect=1, write=1, address=DESC_ADDR, writedata=0, byteenable=4'b1000 (clears only the flag byte); frames_done+1; then GAP.
REQ-028 GAP: count POLL_GAP cycles, then IDLE.
REQ-029 Bus outputs outside READ/POLL/CLEAR: chipselect=0, write=0, address=0, writedata=0, byteenable=4'b0000.
REQ-030 enable is sampled only in IDLE; deasserting enable mid-frame does not abort the frame, and the CLEAR write still occurs.
REQ-031 Minimum per-word cost is 3 cycles (READ, FETCH, SEND with st_ready already high).
REQ-032 Address arithmetic is 10-bit modulo; LEN=1023 with DESC_ADDR=0 reads addresses 1..1023.

Reset
REQ-033 On reset=1, state=IDLE, idx=0, latched LEN=0, frames_done=0, and the GAP counter=0.
REQ-034 On reset=1, all outputs are 0 (byteenable=0).
REQ-035 Reset asserted mid-frame aborts immediately: no CLEAR write is issued and the descriptor remains set in memory.

Verification
REQ-036 Mem[0]=0x00000000, enable=1 -> a POLL read every POLL_GAP+3 cycles, st_valid never asserts, and no write occurs.
REQ-037 Mem[0]=0x80000003, Mem[1..3]=A,B,C, st_ready=1 -> stream A(sop),B,C(eop), 3 cycles apart; then write addr 0, be=1000, data 0; mem[0]=0x00000003; frames_done=1.
REQ-038 Mem[0]=0x80000000 -> no stream output, the CLEAR write follows CHECK in the next cycle, and frames_done increments.
REQ-039 Mem[0]=0x80000001 with st_ready held low 10 cycles -> st_valid high with stable data, sop=eop=1 throughout, and CLEAR only after ready.
REQ-040 DESC_ADDR=1022, LEN=3 -> reads addresses 1023, 0, 1 in order.
REQ-041 Reset asserted during SEND of word 2 -> all outputs 0 next edge; mem[DESC_ADDR] is unchanged; after release, the frame restarts from word 1 on the next poll.
